// File: rtl/huffman_canon_gen.sv
// huffman_canon_gen
// Canonical Huffman code generator for the encoder path. It takes one code
// length per symbol, in symbol order, and builds the first code of every
// length from the length histogram. It then streams (symbol, length, code)
// triples to the table writer in symbol order and skips unused symbols.
// An oversubscribed length set, or a length above MAXLEN, raises the sticky
// Err flag. In that case the run ends without emitting anything.
//
// Ports
//   Clk_in, n_Rst          clock (rising edge), asynchronous active-low reset
//   Start_code             start request, honoured only while idle
//   Len_valid/Len_ready    handshake for Len_data (one length per symbol)
//   Code_valid/Code_ready  handshake for the Code_sym/Code_len/Code_data triple
//   Busy                   high whenever a run is in progress (incl. DONE)
//   Done                   one-cycle pulse at the end of a run
//   Err                    sticky error, cleared by the next accepted start
module huffman_canon_gen #(
    parameter int NSYM   = 10,
    parameter int MAXLEN = 13,
    parameter int LENW   = 4,
    parameter int SYMW   = 4
) (
    input  logic              Clk_in,
    input  logic              n_Rst,
    input  logic              Start_code,
    input  logic              Len_valid,
    input  logic [LENW-1:0]   Len_data,
    output logic              Len_ready,
    output logic              Code_valid,
    input  logic              Code_ready,
    output logic [SYMW-1:0]   Code_sym,
    output logic [LENW-1:0]   Code_len,
    output logic [MAXLEN-1:0] Code_data,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int CW  = MAXLEN + 1;
    localparam int BCW = $clog2(NSYM + 1);
    localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);
    localparam logic [LENW-1:0] ONE_L    = LENW'(1);
    localparam logic [SYMW-1:0] LAST_SYM = SYMW'(NSYM - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRST, S_EMIT, S_DONE} state_t;

    state_t state, state_nxt;

    logic [LENW-1:0] len_q     [NSYM];
    logic [BCW-1:0]  bl_count  [MAXLEN+1];
    logic [CW-1:0]   next_code [MAXLEN+1];
    logic [CW-1:0]   code;
    logic [LENW-1:0] b;
    logic [SYMW-1:0] cnt;
    logic            issued;
    logic            err_q;

    logic            len_take;
    logic            slot_take;
    logic            last_sym;
    logic [LENW-1:0] cur_len;
    logic [CW-1:0]   prev_count;
    logic [CW-1:0]   code_nxt;
    logic [CW:0]     kraft_sum;
    logic [CW:0]     kraft_limit;
    logic            kraft_fail;

    // Shared decode for the datapath and FSM. The first-code recurrence
    // treats bl_count[0] as zero, so unused symbols never shift the codes.
    // The Kraft sum is one bit wider than the code arithmetic, so the
    // comparison against 2^b cannot wrap.
    always_comb begin
        len_take    = (state == S_LOAD) && Len_valid;
        slot_take   = !Code_valid || Code_ready;
        last_sym    = (cnt == LAST_SYM);
        cur_len     = len_q[cnt];
        prev_count  = (b == ONE_L) ? '0 : CW'(bl_count[b - ONE_L]);
        code_nxt    = (code + prev_count) << 1;
        kraft_sum   = {1'b0, code_nxt} + (CW+1)'(bl_count[b]);
        kraft_limit = (CW+1)'(1) << b;
        kraft_fail  = (state == S_FIRST) && (kraft_sum > kraft_limit);
    end

    // State register.
    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. EMIT ends in one of two ways. If the final slot is
    // a skip, the run ends in that same cycle. If the final triple was
    // issued, the run ends once that triple has been taken downstream.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start_code) state_nxt = S_LOAD;
            S_LOAD:  if (len_take && last_sym) state_nxt = S_FIRST;
            S_FIRST: if (b == MAXLEN_L) state_nxt = (err_q || kraft_fail) ? S_DONE : S_EMIT;
            S_EMIT: begin
                if (slot_take) begin
                    if (issued) begin
                        state_nxt = S_DONE;
                    end else if (last_sym && (cur_len == '0)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign Len_ready = (state == S_LOAD);
    assign Busy      = (state != S_IDLE);
    assign Done      = (state == S_DONE);
    assign Err       = err_q;

    // Datapath. LOAD builds the length histogram. FIRST walks b = 1..MAXLEN
    // and records the first code of each length. EMIT hands out codes and
    // post-increments next_code for the length just used. A new slot is
    // only taken when the output register is empty or being drained, so a
    // stalled triple stays put.
    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            for (int i = 0; i < NSYM; i++) begin
                len_q[i] <= '0;
            end
            for (int i = 0; i <= MAXLEN; i++) begin
                bl_count[i]  <= '0;
                next_code[i] <= '0;
            end
            code       <= '0;
            b          <= ONE_L;
            cnt        <= '0;
            issued     <= 1'b0;
            err_q      <= 1'b0;
            Code_valid <= 1'b0;
            Code_sym   <= '0;
            Code_len   <= '0;
            Code_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start_code) begin
                        for (int i = 0; i <= MAXLEN; i++) begin
                            bl_count[i] <= '0;
                        end
                        err_q  <= 1'b0;
                        cnt    <= '0;
                        issued <= 1'b0;
                        code   <= '0;
                        b      <= ONE_L;
                    end
                end
                S_LOAD: begin
                    if (len_take) begin
                        if (Len_data > MAXLEN_L) begin
                            len_q[cnt] <= '0;
                            err_q      <= 1'b1;
                        end else begin
                            len_q[cnt] <= Len_data;
                            if (Len_data != '0) begin
                                bl_count[Len_data] <= bl_count[Len_data] + 1'b1;
                            end
                        end
                        cnt <= last_sym ? '0 : cnt + 1'b1;
                    end
                end
                S_FIRST: begin
                    next_code[b] <= code_nxt;
                    code         <= code_nxt;
                    b            <= b + ONE_L;
                    if (kraft_fail) begin
                        err_q <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (slot_take) begin
                        if (issued) begin
                            Code_valid <= 1'b0;
                        end else begin
                            if (cur_len != '0) begin
                                Code_valid         <= 1'b1;
                                Code_sym           <= cnt;
                                Code_len           <= cur_len;
                                Code_data          <= next_code[cur_len][MAXLEN-1:0];
                                next_code[cur_len] <= next_code[cur_len] + 1'b1;
                            end else begin
                                Code_valid <= 1'b0;
                            end
                            if (last_sym) begin
                                issued <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    Code_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_canon_gen.sv
// tb_huffman_canon_gen
// Self-checking bench for huffman_canon_gen. It drives the default build
// (NSYM=10, MAXLEN=13) and a wide build (NSYM=20, MAXLEN=15, SYMW=5).
// Input handshakes, shared inputs are steered by 'sel'.
// Expected codes come from a textbook canonical-code assignment. That
// assignment walks lengths in increasing order and hands out consecutive
// codes. Expected errors come from a running Kraft sum.
module tb_huffman_canon_gen;

    logic        Clk_in     = 1'b0;
    logic        n_Rst      = 1'b1;
    logic        Start_code = 1'b0;
    logic        Len_valid  = 1'b0;
    logic        Code_ready = 1'b0;
    logic [3:0]  Len_data   = '0;
    logic        sel        = 1'b0;

    logic        lr1, cv1, busy1, done1, err1;
    logic [3:0]  sym1, len1;
    logic [12:0] code1;
    logic        lr2, cv2, busy2, done2, err2;
    logic [4:0]  sym2;
    logic [3:0]  len2;
    logic [14:0] code2;

    logic        o_lr, o_cv, o_busy, o_done, o_err;
    logic [7:0]  o_sym, o_len;
    logic [15:0] o_code;

    int checks;
    int errors;
    int lens [20];
    int canon [10] = '{2, 2, 3, 3, 3, 4, 5, 5, 0, 0};
    int exp_sym[$];
    int exp_len[$];
    int exp_code[$];
    int exp_err;
    int kraft_level;

    huffman_canon_gen dut1 (
        .Clk_in(Clk_in), .n_Rst(n_Rst), .Start_code(Start_code & ~sel),
        .Len_valid(Len_valid), .Len_data(Len_data), .Len_ready(lr1),
        .Code_valid(cv1), .Code_ready(Code_ready), .Code_sym(sym1),
        .Code_len(len1), .Code_data(code1), .Busy(busy1), .Done(done1), .Err(err1)
    );

    huffman_canon_gen #(.NSYM(20), .MAXLEN(15), .LENW(4), .SYMW(5)) dut2 (
        .Clk_in(Clk_in), .n_Rst(n_Rst), .Start_code(Start_code & sel),
        .Len_valid(Len_valid), .Len_data(Len_data), .Len_ready(lr2),
        .Code_valid(cv2), .Code_ready(Code_ready), .Code_sym(sym2),
        .Code_len(len2), .Code_data(code2), .Busy(busy2), .Done(done2), .Err(err2)
    );

    always #5 Clk_in = ~Clk_in;

    // View of whichever instance the current run targets.
    always_comb begin
        o_lr   = sel ? lr2   : lr1;
        o_cv   = sel ? cv2   : cv1;
        o_busy = sel ? busy2 : busy1;
        o_done = sel ? done2 : done1;
        o_err  = sel ? err2  : err1;
        o_sym  = sel ? 8'(sym2)   : 8'(sym1);
        o_len  = sel ? 8'(len2)   : 8'(len1);
        o_code = sel ? 16'(code2) : 16'(code1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model. Codes are handed out length by length, consecutively,
    // doubling between lengths. An error is expected for a length above
    // maxlen or when the running Kraft sum first exceeds one.
    function automatic void build_model(input int nsym, input int maxlen);
        int eff [20];
        int code_of [20];
        int code;
        int kraft;
        exp_sym.delete();
        exp_len.delete();
        exp_code.delete();
        exp_err     = 0;
        kraft_level = 0;
        kraft       = 0;
        for (int i = 0; i < nsym; i++) begin
            code_of[i] = 0;
            if (lens[i] > maxlen) begin
                exp_err = 1;
                eff[i]  = 0;
            end else begin
                eff[i] = lens[i];
            end
        end
        for (int l = 1; l <= maxlen; l++) begin
            for (int i = 0; i < nsym; i++) if (eff[i] == l) kraft += 1 << (maxlen - l);
            if (kraft > (1 << maxlen) && kraft_level == 0) kraft_level = l;
        end
        if (kraft_level != 0) exp_err = 1;
        code = 0;
        for (int l = 1; l <= maxlen; l++) begin
            for (int i = 0; i < nsym; i++) begin
                if (eff[i] == l) begin
                    code_of[i] = code;
                    code++;
                end
            end
            code = code << 1;
        end
        if (exp_err == 0) begin
            for (int i = 0; i < nsym; i++) begin
                if (eff[i] != 0) begin
                    exp_sym.push_back(i);
                    exp_len.push_back(eff[i]);
                    exp_code.push_back(code_of[i]);
                end
            end
        end
    endfunction

    task automatic set_canon();
        for (int i = 0; i < 20; i++) lens[i] = (i < 10) ? canon[i] : 0;
    endtask

    // One complete run. rmode: 0 = Code_ready high, 1 = random,
    // 2 = hold Code_ready low for three cycles while the third triple shows.
    task automatic applyStimulus(input bit s, input int rmode, input bit vrand,
                                 input bit spam, input int abort_at);
        int nsym, maxlen, k, acc, rx, L, stalls, bp, first_v, done_c, bad_c;
        int lastnz, first_nz, nq;
        bit done_seen, err_exp;
        nsym   = s ? 20 : 10;
        maxlen = s ? 15 : 13;
        build_model(nsym, maxlen);
        nq       = exp_sym.size();
        lastnz   = (lens[nsym-1] != 0 && lens[nsym-1] <= maxlen) ? 1 : 0;
        first_nz = (nq > 0) ? exp_sym[0] : 0;
        k = 0; acc = 0; rx = 0; L = 0; stalls = 0; bp = 0;
        first_v = -1; done_c = -1; bad_c = 0; done_seen = 0;
        @(negedge Clk_in);
        sel        = s;
        Start_code = 1'b1;
        Len_valid  = 1'b0;
        Code_ready = 1'b1;
        Len_data   = 4'(lens[0]);
        while (!done_seen && k < 400) begin
            @(negedge Clk_in);
            k++;
            Start_code = spam;
            err_exp = (bad_c > 0 && k > bad_c) || (kraft_level > 0 && L > 0 && k > L + kraft_level);
            check("busy", o_busy, 1);
            check("len_ready", o_lr, (acc < nsym) ? 1 : 0);
            check("err", o_err, err_exp);
            if (o_cv) begin
                if (first_v < 0) first_v = k;
                if (rx < nq) begin
                    check("code_sym", o_sym, exp_sym[rx]);
                    check("code_len", o_len, exp_len[rx]);
                    check("code_data", o_code, exp_code[rx]);
                end else begin
                    check("code_valid", o_cv, 0);
                end
            end
            if (abort_at > 0 && k == abort_at) break;
            if (o_done) begin
                done_seen  = 1;
                done_c     = k;
                Start_code = 1'b0;
            end else begin
                Len_valid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
                Len_data  = 4'(lens[(acc < nsym) ? acc : 0]);
                if (o_lr && Len_valid) begin
                    if (lens[acc] > maxlen && bad_c == 0) bad_c = k;
                    acc++;
                    if (acc == nsym) L = k;
                end
                case (rmode)
                    0: Code_ready = 1'b1;
                    1: Code_ready = ($urandom_range(0, 2) != 0);
                    default: begin
                        Code_ready = !(o_cv && rx == 2 && bp < 3);
                        if (!Code_ready) bp++;
                    end
                endcase
                if (o_cv && Code_ready) rx++;
                else if (o_cv) stalls++;
            end
        end
        Len_valid  = 1'b0;
        Start_code = 1'b0;
        if (abort_at > 0) begin
            #2 n_Rst = 1'b0;
            #1;
            check("rst_len_ready", o_lr, 0);
            check("rst_code_valid", o_cv, 0);
            check("rst_code_sym", o_sym, 0);
            check("rst_code_len", o_len, 0);
            check("rst_code_data", o_code, 0);
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            check("rst_err", o_err, 0);
            @(negedge Clk_in);
            n_Rst = 1'b1;
            repeat (3) begin
                @(negedge Clk_in);
                check("post_rst_done", o_done, 0);
                check("post_rst_busy", o_busy, 0);
            end
        end else begin
            checkOutput(done_seen, rx, nq, first_v, done_c, L, maxlen, nsym,
                        stalls, lastnz, first_nz);
        end
    endtask

    // End-of-run checks, then two idle cycles with Err expected to hold.
    task automatic checkOutput(input bit done_seen, input int rx, input int nq,
                               input int first_v, input int done_c, input int L,
                               input int maxlen, input int nsym, input int stalls,
                               input int lastnz, input int first_nz);
        check("done_seen", done_seen, 1);
        check("triple_count", rx, nq);
        if (nq > 0) check("first_valid_cycle", first_v, L + maxlen + 2 + first_nz);
        else        check("no_code_valid", first_v, -1);
        check("done_cycle", done_c,
              (exp_err != 0) ? L + maxlen + 1 : L + maxlen + 1 + nsym + stalls + lastnz);
        repeat (2) begin
            @(negedge Clk_in);
            check("idle_done", o_done, 0);
            check("idle_busy", o_busy, 0);
            check("idle_err", o_err, exp_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        #1 n_Rst = 1'b0;
        repeat (2) @(negedge Clk_in);
        check("reset_len_ready", o_lr, 0);
        check("reset_code_valid", o_cv, 0);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_err", o_err, 0);
        check("reset_code_data", o_code, 0);
        n_Rst = 1'b1;
        @(negedge Clk_in);
        check("idle_busy0", o_busy, 0);

        $display("[TB] canonical assignment");
        set_canon();
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] backpressure on symbol 2");
        applyStimulus(0, 2, 0, 0, 0);

        $display("[TB] oversubscribed code");
        for (int i = 0; i < 20; i++) lens[i] = (i < 3) ? 1 : 0;
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] length out of range, then clean run clears Err");
        set_canon();
        lens[3] = 14;
        applyStimulus(0, 0, 0, 0, 0);
        set_canon();
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] all-zero lengths");
        for (int i = 0; i < 20; i++) lens[i] = 0;
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] start held high during the run");
        set_canon();
        applyStimulus(0, 0, 0, 1, 0);

        $display("[TB] reset mid-EMIT, then clean run");
        applyStimulus(0, 0, 0, 0, 28);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] wide build NSYM=20 MAXLEN=15");
        for (int i = 0; i < 20; i++) lens[i] = (i < 15) ? i + 1 : ((i == 15) ? 15 : 0);
        applyStimulus(1, 0, 0, 0, 0);

        $display("[TB] randomized runs");
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 20; i++) begin
                if (i >= 10 || $urandom_range(0, 4) == 0) lens[i] = 0;
                else lens[i] = $urandom_range(it[0] ? 1 : 4, 13);
            end
            if (it == 5) lens[$urandom_range(0, 9)] = 15;
            applyStimulus(0, 1, 1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
